ecpri_ram_arbiter: RTL

ECPRI_RAM_ARBITER -- requirements
Module: ecpri_ram_arbiter

---
 rtl/ecpri_pkg.sv | 25 ++
 rtl/rr_select3.sv | 32 +++
 rtl/ecpri_ram_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ecpri_pkg.sv
// Shared types and constants for the eCPRI RAM arbiter.
package ecpri_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StTurn  = 2'd2
  } arb_state_e;

  localparam logic [1:0] REQ_RX  = 2'd0;
  localparam logic [1:0] REQ_TX  = 2'd1;
  localparam logic [1:0] REQ_CPU = 2'd2;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_MAX_BURST  = 64;

  // One-hot (3 bit) to requester index; all-zero maps to REQ_RX.
  function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
    if (oh[2]) return REQ_CPU;
    if (oh[1]) return REQ_TX;
    return REQ_RX;
  endfunction

endpackage

// File: rtl/rr_select3.sv
// Three-way round-robin winner select: priority starts just after 'last'.
module rr_select3
  import ecpri_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] win
);

  // Walk the requests in rotated order and pick the first one set.
  always_comb begin
    win = '0;
    case (last)
      REQ_RX: begin
        if      (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      REQ_TX: begin
        if      (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if      (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/ecpri_ram_arbiter.sv
// Arbitrates one external RAM port among rx, tx and cpu with round-robin,
// a burst limit and one turnaround cycle between grants.
// Optional: define ECPRI_ARB_CPU_PRIO_EN to give cpu fixed top priority and
// exempt it from the burst limit.
module ecpri_ram_arbiter
  import ecpri_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_rx,
  input  logic                  we_rx,
  input  logic [ADDR_WIDTH-1:0] addr_rx,
  input  logic [DATA_WIDTH-1:0] wdata_rx,
  output logic                  gnt_rx,
  output logic                  rvalid_rx,
  input  logic                  req_tx,
  input  logic                  we_tx,
  input  logic [ADDR_WIDTH-1:0] addr_tx,
  input  logic [DATA_WIDTH-1:0] wdata_tx,
  output logic                  gnt_tx,
  output logic                  rvalid_tx,
  input  logic                  req_cpu,
  input  logic                  we_cpu,
  input  logic [ADDR_WIDTH-1:0] addr_cpu,
  input  logic [DATA_WIDTH-1:0] wdata_cpu,
  output logic                  gnt_cpu,
  output logic                  rvalid_cpu,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [1:0]       owner_q, owner_d;  // current owner; holds last owner outside GRANT
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rvalid_q, rvalid_d;

  logic [2:0]            req_vec, owner_oh, rr_req, rr_win, win;
  logic [1:0]            rr_last, win_idx;
  logic                  owner_req, owner_we, others_req, burst_hit, burst_exempt, access;
  logic [ADDR_WIDTH-1:0] owner_addr;
  logic [DATA_WIDTH-1:0] owner_wdata;

  assign req_vec    = {req_cpu, req_tx, req_rx};
  assign owner_oh   = 3'b001 << owner_q;
  assign others_req = |(req_vec & ~owner_oh);
  // Count already holds the cycles granted before this one.
  assign burst_hit  = (cnt_q >= CNT_W'(MAX_BURST - 1));

`ifdef ECPRI_ARB_CPU_PRIO_EN
  logic last_rt_q;  // 0: rx was the last rx/tx owner, 1: tx

  assign rr_req       = {1'b0, req_tx, req_rx};
  assign rr_last      = last_rt_q ? REQ_TX : REQ_RX;
  assign win          = req_cpu ? 3'b100 : rr_win;
  assign burst_exempt = (owner_q == REQ_CPU);

  // Track rx/tx rotation separately so cpu grants do not disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_rt_q <= 1'b1;
    end else if (state_q != StGrant && (|req_vec) && win_idx != REQ_CPU) begin
      last_rt_q <= win_idx[0];
    end
  end
`else
  assign rr_req       = req_vec;
  assign rr_last      = owner_q;
  assign win          = rr_win;
  assign burst_exempt = 1'b0;
`endif

  assign win_idx = onehot3_to_idx(win);

  rr_select3 u_rr_select3 (
    .req  (rr_req),
    .last (rr_last),
    .win  (rr_win)
  );

  // Select the owner's request signals.
  always_comb begin
    owner_req   = 1'b0;
    owner_we    = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    unique case (owner_q)
      REQ_RX: begin
        owner_req = req_rx; owner_we = we_rx; owner_addr = addr_rx; owner_wdata = wdata_rx;
      end
      REQ_TX: begin
        owner_req = req_tx; owner_we = we_tx; owner_addr = addr_tx; owner_wdata = wdata_tx;
      end
      default: begin
        owner_req = req_cpu; owner_we = we_cpu; owner_addr = addr_cpu; owner_wdata = wdata_cpu;
      end
    endcase
  end

  // Next-state, owner selection and burst counting.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      StIdle, StTurn: begin
        if (|req_vec) begin
          state_d = StGrant;
          owner_d = win_idx;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          state_d = StTurn;
        end else begin
          access = 1'b1;
          if (cnt_q != CNT_W'(MAX_BURST)) cnt_d = cnt_q + 1'b1;
          if (burst_hit && others_req && !burst_exempt) state_d = StTurn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grants, RAM strobes and read-valid tagging for this cycle's access.
  always_comb begin
    gnt_rx    = access && (owner_q == REQ_RX);
    gnt_tx    = access && (owner_q == REQ_TX);
    gnt_cpu   = access && (owner_q == REQ_CPU);
    ram_cs    = access;
    ram_we    = access && owner_we;
    ram_oe    = access && !owner_we;
    ram_addr  = access ? owner_addr : '0;
    ram_wdata = access ? owner_wdata : '0;
    rvalid_d  = (access && !owner_we) ? owner_oh : 3'b000;
  end

  assign rvalid_rx  = rvalid_q[0];
  assign rvalid_tx  = rvalid_q[1];
  assign rvalid_cpu = rvalid_q[2];
  // RAM returns read data one cycle after the access.
  assign rdata      = (|rvalid_q) ? ram_rdata : '0;

  // State registers; reset starts with cpu as last owner so rx wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      owner_q  <= REQ_CPU;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule
